// File: rtl/header_encoder_if.sv
// header_encoder_if -- start handshake and serial-link bundle for header_encoder.
//
// Handshake: iSTART is the valid and oREADY is the ready. A header transfers
// on a rising clock edge where both are high. iHEADER only matters on that
// edge. iSTART while oREADY is low is dropped and never queued.
//
// Signals:
//   iSTART   host -> encoder  request to send
//   iHEADER  host -> encoder  header word, WL bits
//   oREADY   encoder -> host  encoder idle, will accept iSTART
//   oCSn     encoder -> pad   active-low frame select
//   oSCLK    encoder -> pad   serial clock, idle low
//   oMOSI    encoder -> pad   serial data, MSB first
//   oEN      encoder -> pad   one-cycle strobe at each oSCLK rising edge
//   oDONE    encoder -> host  one-cycle frame-complete pulse
//   oSTATE   encoder -> debug current FSM state (0 IDLE, 1 SHIFT, 2 TRAIL)
interface header_encoder_if #(
  parameter int WL = 6
);
  logic          iSTART;
  logic [WL-1:0] iHEADER;
  logic          oREADY;
  logic          oCSn;
  logic          oSCLK;
  logic          oMOSI;
  logic          oEN;
  logic          oDONE;
  logic [1:0]    oSTATE;

  modport master (
    output iSTART, iHEADER,
    input  oREADY, oCSn, oSCLK, oMOSI, oEN, oDONE, oSTATE
  );

  modport slave (
    input  iSTART, iHEADER,
    output oREADY, oCSn, oSCLK, oMOSI, oEN, oDONE, oSTATE
  );
endinterface

// File: rtl/header_encoder.sv
// header_encoder -- transmit side of the header link.
//
// Latches a WL-bit header on the start handshake and shifts it out MSB first
// on oMOSI with an active-low select, a divided serial clock and a one-cycle
// sample strobe (oEN) at every oSCLK rising edge. Each bit lasts 2*DIV cycles
// (DIV low, DIV high); the frame ends with DIV trailing cycles before oCSn
// rises together with a one-cycle oDONE pulse.
//
// Parameters:
//   WL   header width in bits (>= 1)
//   DIV  half-period of oSCLK in iCLK cycles (>= 1)
//
// Ports:
//   iCLK   system clock, rising edge
//   iRSTn  asynchronous active-low reset
//   iCLR   synchronous clear, overrides everything including iSTART
//   hif    header_encoder_if.slave: iSTART/iHEADER in, serial outputs out
//
// Build option: define HEADER_PARITY_EN to append an odd-parity bit
// (~^header) after the header LSB, making the frame WL+1 bits long.
module header_encoder #(
  parameter int WL  = 6,
  parameter int DIV = 2
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iCLR,
  header_encoder_if.slave hif
);

`ifdef HEADER_PARITY_EN
  localparam int NB = WL + 1;
`else
  localparam int NB = WL;
`endif

  // Divide counter spans a whole bit (0 .. 2*DIV-1); bit counter 0 .. NB-1.
  localparam int DW = $clog2(DIV) + 1;
  localparam int BW = $clog2(NB) + 1;

  localparam logic [DW-1:0] DIV_HI     = DW'(DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * DIV - 1);
  localparam logic [DW-1:0] TRAIL_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRAIL = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NB-1:0] sreg_q, sreg_d;
  logic          done_d;
  logic          ready_q, csn_q, sclk_q, mosi_q, en_q, done_q;
  logic [NB-1:0] load_val;

`ifdef HEADER_PARITY_EN
  assign load_val = {hif.iHEADER, ~^hif.iHEADER};
`else
  assign load_val = hif.iHEADER;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    done_d  = 1'b0;
    if (iCLR) begin
      state_d = IDLE;
      div_d   = '0;
      bit_d   = '0;
      sreg_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hif.iSTART) begin
            state_d = SHIFT;
            div_d   = '0;
            bit_d   = '0;
            sreg_d  = load_val;
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bit_q == BIT_LAST) begin
              // Last bit stays in the MSB so oMOSI holds it through TRAIL.
              state_d = TRAIL;
            end else begin
              bit_d  = bit_q + BW'(1);
              sreg_d = sreg_q << 1;
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        TRAIL: begin
          if (div_q == TRAIL_LAST) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe, without a combinational path to the pads.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      ready_q <= 1'b1;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      ready_q <= (state_d == IDLE);
      csn_q   <= (state_d == IDLE);
      sclk_q  <= (state_d == SHIFT) && (div_d >= DIV_HI);
      en_q    <= (state_d == SHIFT) && (div_d == DIV_HI);
      mosi_q  <= (state_d != IDLE) && sreg_d[NB-1];
      done_q  <= done_d;
    end
  end

  assign hif.oREADY = ready_q;
  assign hif.oCSn   = csn_q;
  assign hif.oSCLK  = sclk_q;
  assign hif.oMOSI  = mosi_q;
  assign hif.oEN    = en_q;
  assign hif.oDONE  = done_q;
  assign hif.oSTATE = state_q;

endmodule

// File: tb/tb_header_encoder.sv
// tb_header_encoder -- self-checking bench for header_encoder (WL=6, DIV=2).
// Cycle numbering: frame_t is the count of the edge that accepted iSTART;
// the cycle following edge n is called cycle n+1.
module tb_header_encoder;
  localparam int WL  = 6;
  localparam int DIV = 2;
`ifdef HEADER_PARITY_EN
  localparam int NB = WL + 1;
`else
  localparam int NB = WL;
`endif
  localparam int DONE_OFF    = 1 + (2 * NB + 1) * DIV;
  localparam int LAST_EN_OFF = 1 + DIV + 2 * DIV * (NB - 1);

  // ---------------- clock / reset ----------------
  logic iCLK  = 1'b0;
  logic iRSTn = 1'b0;
  logic iCLR  = 1'b0;

  header_encoder_if #(.WL(WL)) hif ();

  header_encoder #(.WL(WL), .DIV(DIV)) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iCLR  (iCLR),
    .hif   (hif)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_t = 0;
  int accepts = 0;
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] rx = '0;
  int rx_cnt = 0;
  int en_total = 0;
  int last_en = 0;
  int done_cyc = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Expected serial frame: header, then the odd-parity bit when NB = WL+1.
  function automatic logic [NB-1:0] exp_bits(input logic [WL-1:0] hdr, input logic par);
    logic [WL:0] full;
    full = {hdr, par};
    return NB'(full >> (WL + 1 - NB));
  endfunction

  // Edge counter and acceptance tracker (inputs are stable at posedge).
  initial forever begin
    @(posedge iCLK);
    cyc++;
    if (iRSTn && !iCLR && hif.iSTART && hif.oREADY) begin
      frame_t = cyc;
      accepts++;
    end
  end

  // Output monitor: timing checks plus scoreboard compare (acts as decoder).
  initial forever begin
    @(negedge iCLK);
    if (!iRSTn) begin
      rx_cnt = 0;
    end else begin
      if (!hif.oCSn) begin
        int o;
        o = cyc - frame_t;  // 0 for the first cycle of the frame
        check("sclk_shape", hif.oSCLK,
              (o < 2 * DIV * NB) ? (((o % (2 * DIV)) >= DIV) ? 1 : 0) : 0);
      end
      if (hif.oEN) begin
        check("en_time", cyc + 1 - frame_t, 1 + DIV + 2 * DIV * rx_cnt);
        rx = (rx << 1) | NB'(hif.oMOSI);
        rx_cnt++;
        en_total++;
        if (rx_cnt == NB) begin
          last_en = cyc + 1;
          check("sb_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
          if (exp_q.size() != 0) check("frame_bits", rx, exp_q.pop_front());
          rx_cnt = 0;
        end
      end
      if (hif.oDONE) begin
        done_cyc = cyc + 1;
        done_cnt++;
      end
      if (hif.oCSn) rx_cnt = 0;
    end
  end

  // ---------------- driver tasks (call at a negedge) ----------------
  task automatic wait_ready();
    for (int i = 0; i < 200 && !hif.oREADY; i++) @(negedge iCLK);
  endtask

  task automatic send(input logic [WL-1:0] hdr, input logic par);
    wait_ready();
    hif.iSTART  = 1'b1;
    hif.iHEADER = hdr;
    exp_q.push_back(exp_bits(hdr, par));
    @(negedge iCLK);
    hif.iSTART  = 1'b0;
    hif.iHEADER = WL'($urandom_range(0, (1 << WL) - 1));
  endtask

  task automatic wait_done(input int budget, output int dc);
    int c0;
    c0 = done_cnt;
    dc = -1000;
    for (int i = 0; i < budget; i++) begin
      @(negedge iCLK);
      #1;
      if (done_cnt != c0) begin
        dc = done_cyc;
        break;
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc + 1 < target) @(negedge iCLK);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_csn"},   hif.oCSn,   1);
    check({tag, "_sclk"},  hif.oSCLK,  0);
    check({tag, "_mosi"},  hif.oMOSI,  0);
    check({tag, "_en"},    hif.oEN,    0);
    check({tag, "_done"},  hif.oDONE,  0);
    check({tag, "_ready"}, hif.oREADY, 1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [WL-1:0] hdr;
    logic          par;       // hand-computed ~^hdr
    int            en_cnt;
    int            done_off;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, t1, e0, a0, d0, dc, lowc;
    hif.iSTART  = 1'b0;
    hif.iHEADER = '0;

    vecs[0] = '{6'b101101, 1'b1, NB, DONE_OFF};
    vecs[1] = '{6'h00,     1'b1, NB, DONE_OFF};
    vecs[2] = '{6'h3F,     1'b1, NB, DONE_OFF};
    vecs[3] = '{6'h01,     1'b0, NB, DONE_OFF};
    vecs[4] = '{6'h20,     1'b0, NB, DONE_OFF};
    vecs[5] = '{6'h2A,     1'b0, NB, DONE_OFF};

    // Reset state
    repeat (3) @(negedge iCLK);
    check_idle("reset");
    iRSTn = 1'b1;
    @(negedge iCLK);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].hdr, vecs[i].par);
      t0 = frame_t;
      e0 = en_total;
      wait_done(100, dc);
      check("vec_done_time", dc - t0, vecs[i].done_off);
      check("vec_en_count", en_total - e0, vecs[i].en_cnt);
      check("vec_last_en", last_en - t0, LAST_EN_OFF);
      check("vec_done_ready", hif.oREADY, 1);
      check("vec_done_csn", hif.oCSn, 1);
      check("vec_done_mosi", hif.oMOSI, 0);
    end

    // Back-to-back: iSTART held high across the oDONE cycle
    @(negedge iCLK);
    wait_ready();
    a0 = accepts;
    d0 = done_cnt;
    hif.iSTART  = 1'b1;
    hif.iHEADER = 6'h3F;
    exp_q.push_back(exp_bits(6'h3F, 1'b1));
    @(negedge iCLK);
    #1;
    t0 = frame_t;
    hif.iHEADER = 6'h00;
    exp_q.push_back(exp_bits(6'h00, 1'b1));
    for (int i = 0; i < 100 && accepts < a0 + 2; i++) @(negedge iCLK);
    t1 = frame_t;
    hif.iSTART = 1'b0;
    check("b2b_second_accept", t1 - t0, DONE_OFF);
    check("b2b_csn_fall_time", cyc + 1 - t0, DONE_OFF + 1);
    check("b2b_csn_low", hif.oCSn, 0);
    wait_done(100, dc);
    check("b2b_done_time", dc - t0, 2 * DONE_OFF);
    check("b2b_done_count", done_cnt - d0, 2);

    // Ignored start during a frame
    @(negedge iCLK);
    send(6'h2A, 1'b0);
    t0 = frame_t;
    a0 = accepts;
    wait_until(t0 + 10);
    hif.iSTART  = 1'b1;
    hif.iHEADER = 6'h15;
    @(negedge iCLK);
    hif.iSTART  = 1'b0;
    wait_done(100, dc);
    check("ign_done_time", dc - t0, DONE_OFF);
    check("ign_no_accept", accepts - a0, 0);
    lowc = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (!hif.oCSn) lowc++;
    end
    check("ign_no_second_frame", lowc, 0);

    // Abort with iCLR, then restart
    send(6'h33, 1'b1);
    t0 = frame_t;
    d0 = done_cnt;
    wait_until(t0 + 12);
    iCLR = 1'b1;
    @(negedge iCLK);
    iCLR = 1'b0;
    check("abort_time", cyc + 1 - t0, 13);
    check_idle("abort");
    void'(exp_q.pop_front());
    @(negedge iCLK);
    send(6'h0C, 1'b1);
    t1 = frame_t;
    check("abort_restart_t", t1 - t0, 14);
    wait_done(100, dc);
    check("abort_restart_done", dc - t1, DONE_OFF);
    check("abort_no_done", done_cnt - d0, 1);

    // Simultaneous iCLR and iSTART: clear wins
    @(negedge iCLK);
    e0 = en_total;
    iCLR        = 1'b1;
    hif.iSTART  = 1'b1;
    hif.iHEADER = 6'h2D;
    @(negedge iCLK);
    iCLR       = 1'b0;
    hif.iSTART = 1'b0;
    check("clr_start_csn", hif.oCSn, 1);
    check("clr_start_ready", hif.oREADY, 1);
    repeat (6) @(negedge iCLK);
    check("clr_start_no_en", en_total - e0, 0);

    // Asynchronous reset mid-frame
    send(6'h0F, 1'b1);
    t0 = frame_t;
    wait_until(t0 + 8);
    iRSTn = 1'b0;
    @(negedge iCLK);
    check_idle("rst_mid");
    iRSTn = 1'b1;
    void'(exp_q.pop_front());
    @(negedge iCLK);

    // One more frame after reset to confirm recovery
    send(6'b101101, 1'b1);
    t0 = frame_t;
    wait_done(100, dc);
    check("post_rst_done", dc - t0, DONE_OFF);

    repeat (4) @(negedge iCLK);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
